// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } mem_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Memory stage result is newer than Writeback, so it wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic       reg_write_m,
        input logic [3:0] rd_m,
        input logic       reg_write_w,
        input logic [3:0] rd_w,
        input logic [3:0] ra
    );
        if (reg_write_m && (rd_m == ra)) begin
            return FWD_MEM;
        end else if (reg_write_w && (rd_w == ra)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait-state tracker with timeout; raises o_mem_hold while the
// Memory stage must not advance and latches a sticky error on timeout.
//
// state | meaning
// RUN   | no outstanding access beyond the current cycle
// WAIT  | access issued, waiting for ack; r_wait_cnt counts waited cycles
// ERROR | ack never arrived within TIMEOUT; pipeline frozen until reset
module mem_wait_fsm
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_mem_req,
    input  logic i_mem_ack,
    output logic o_mem_hold,
    output logic o_mem_err
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    mem_state_t      r_state;
    mem_state_t      w_state_nxt;
    logic [CW-1:0]   r_wait_cnt;
    logic [CW-1:0]   w_wait_cnt_nxt;
    logic            r_mem_err;
    logic            w_mem_err_nxt;

    // State, wait counter and sticky error register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_mem_err  <= w_mem_err_nxt;
        end
    end

    // Next-state logic; hold is combinational so an unacked request stalls
    // in the very cycle it is presented, and the acking cycle still holds.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_mem_err_nxt  = r_mem_err;
        o_mem_hold     = 1'b0;
        case (r_state)
            RUN: begin
                if (i_mem_req && !i_mem_ack) begin
                    o_mem_hold     = 1'b1;
                    w_state_nxt    = WAIT;
                    w_wait_cnt_nxt = CW'(1);
                end
            end
            WAIT: begin
                o_mem_hold = 1'b1;
                if (i_mem_ack) begin
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == CW'(TIMEOUT)) begin
                    w_state_nxt   = ERROR;
                    w_mem_err_nxt = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + CW'(1);
                end
            end
            ERROR: begin
                o_mem_hold = 1'b1;
            end
            default: begin
                w_state_nxt    = RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    assign o_mem_err = r_mem_err;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, stage stalls/flushes,
// memory request gating and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       RdE,
    input  logic [3:0]       RdM,
    input  logic [3:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    input  logic             MemReqM,
    input  logic             DMemAck,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             DMemReq,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount
);

    logic             w_ldr_stall;
    logic             w_pc_pend;
    logic             w_mem_hold;
    logic             w_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;

    mem_wait_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_wait_fsm (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_mem_req  (MemReqM),
        .i_mem_ack  (DMemAck),
        .o_mem_hold (w_mem_hold),
        .o_mem_err  (w_mem_err)
    );

    assign ForwardAE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, RA1E);
    assign ForwardBE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, RA2E);

    assign w_ldr_stall = MemtoRegE && ((RA1D == RdE) || (RA2D == RdE));
    assign w_pc_pend   = PCSrcD || PCSrcE || PCSrcM;

    assign StallF = w_ldr_stall || w_pc_pend || w_mem_hold;
    assign StallD = w_ldr_stall || w_mem_hold;
    assign StallE = w_mem_hold;
    assign StallM = w_mem_hold;

    // Flushes are suppressed while memory holds the pipe so a frozen stage
    // keeps its instruction; the pending flush re-fires once it advances.
    assign FlushD = !w_mem_hold && (w_pc_pend || PCSrcW || BranchTakenE);
    assign FlushE = !w_mem_hold && (w_ldr_stall || BranchTakenE);
    assign FlushW = w_mem_hold;

    // MemErr is only set on entry to ERROR, so it doubles as the ERROR flag.
    assign DMemReq = MemReqM && !w_mem_err;
    assign MemErr  = w_mem_err;

    // Saturating count of cycles in which fetch was stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (StallF && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign StallCount = r_stall_cnt;

endmodule
